// File: rtl/match_descriptor_sequencer.sv
// Match descriptor sequencer: streams each scene descriptor followed by the whole
// database to the match core, collects one best-match index per scene and
// writes it to the result port, then optionally pads the result stream.
// Optional feature: define MATCH_DESCRIPTOR_SEQUENCER_PAD_EN to pad the result
// stream with NO_MATCH entries up to a multiple of PAD_BLOCK.
module match_descriptor_sequencer #(
    parameter int DESC_W         = 16,
    parameter int WORDS_PER_DESC = 64,
    parameter int IDX_W          = 12,
    parameter int PAD_BLOCK      = 256
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [IDX_W-1:0]  iSceneCount,
    input  logic [IDX_W-1:0]  iDatabaseCount,
    input  logic [DESC_W-1:0] iSceneDesc,
    input  logic [DESC_W-1:0] iDatabaseDesc,
    input  logic              iSceneEmpty,
    input  logic              iDatabaseEmpty,
    output logic              oReadScene,
    output logic              oReadDatabase,
    output logic              oRewindDatabase,
    output logic [DESC_W-1:0] oCoreDesc,
    output logic              oCoreValid,
    output logic              oCoreStartScene,
    output logic              oCoreStartDatabase,
    input  logic              iCoreMatchValid,
    input  logic              iCoreMatch,
    input  logic [IDX_W-1:0]  iCoreMatchIndex,
    output logic [IDX_W-1:0]  oResultIndex,
    output logic              oResultWrite,
    output logic              oBusy,
    output logic              oDone
);

    localparam int WORD_W = (WORDS_PER_DESC > 1) ? $clog2(WORDS_PER_DESC) : 1;
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_DESC - 1);
    localparam logic [IDX_W-1:0]  NO_MATCH  = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_SCENE,
        LOAD_DB,
        DRAIN,
        PAD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]  scene_count;
    logic [IDX_W-1:0]  db_count;
    logic [CNT_W-1:0]  scene_idx;
    logic [CNT_W-1:0]  db_idx;
    logic [CNT_W-1:0]  valid_count;
    logic [CNT_W-1:0]  write_count;
    logic [WORD_W-1:0] word_idx;
    logic              have_match;
    logic [IDX_W-1:0]  match_index;

    logic start_ok;
    logic scene_xfer;
    logic db_xfer;
    logic last_word;
    logic last_db;
    logic last_scene;
    logic counting;
    logic result_due;
    logic pad_needed;

    assign start_ok   = iStart && ((state == IDLE) || (state == DONE));
    assign scene_xfer = oReadScene && !iSceneEmpty;
    assign db_xfer    = oReadDatabase && !iDatabaseEmpty;
    assign last_word  = (word_idx == LAST_WORD);
    assign last_db    = ((db_idx + 1'b1) == {1'b0, db_count});
    assign last_scene = ((scene_idx + 1'b1) == {1'b0, scene_count});
    assign counting   = (state == LOAD_SCENE) || (state == LOAD_DB) || (state == DRAIN);
    assign result_due = counting && iCoreMatchValid && ((valid_count + 1'b1) == {1'b0, db_count});

`ifdef MATCH_DESCRIPTOR_SEQUENCER_PAD_EN
    localparam logic [CNT_W-1:0] PAD_MASK = CNT_W'(PAD_BLOCK - 1);
    assign pad_needed = ((write_count & PAD_MASK) != '0);
`else
    assign pad_needed = 1'b0;
`endif

    assign oBusy = (state != IDLE) && (state != DONE);
    assign oDone = (state == DONE);

    // State register; reset wins over everything, including a start request.
    always_ff @(posedge iClk) begin
        if (iReset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and FIFO read enables (only the FIFO being loaded is read).
    always_comb begin
        state_next    = state;
        oReadScene    = 1'b0;
        oReadDatabase = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (iStart) begin
                    if ((iSceneCount == '0) || (iDatabaseCount == '0)) state_next = PAD;
                    else                                               state_next = LOAD_SCENE;
                end
            end
            LOAD_SCENE: begin
                oReadScene = 1'b1;
                if (scene_xfer && last_word) state_next = LOAD_DB;
            end
            LOAD_DB: begin
                oReadDatabase = 1'b1;
                if (db_xfer && last_word && last_db) state_next = last_scene ? DRAIN : LOAD_SCENE;
            end
            DRAIN: begin
                if (write_count == {1'b0, scene_count}) state_next = PAD;
            end
            PAD: begin
                if (!pad_needed) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, registered core stream, match tracking and result/pad writes.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            scene_count        <= '0;
            db_count           <= '0;
            scene_idx          <= '0;
            db_idx             <= '0;
            valid_count        <= '0;
            write_count        <= '0;
            word_idx           <= '0;
            have_match         <= 1'b0;
            match_index        <= '0;
            oCoreDesc          <= '0;
            oCoreValid         <= 1'b0;
            oCoreStartScene    <= 1'b0;
            oCoreStartDatabase <= 1'b0;
            oRewindDatabase    <= 1'b0;
            oResultWrite       <= 1'b0;
            oResultIndex       <= NO_MATCH;
        end else begin
            oCoreValid         <= 1'b0;
            oCoreStartScene    <= 1'b0;
            oCoreStartDatabase <= 1'b0;
            oRewindDatabase    <= 1'b0;
            oResultWrite       <= 1'b0;
            oResultIndex       <= NO_MATCH;
            if (start_ok) begin
                scene_count <= iSceneCount;
                db_count    <= iDatabaseCount;
                scene_idx   <= '0;
                db_idx      <= '0;
                valid_count <= '0;
                write_count <= '0;
                word_idx    <= '0;
                have_match  <= 1'b0;
            end else begin
                if (scene_xfer) begin
                    oCoreDesc       <= iSceneDesc;
                    oCoreValid      <= 1'b1;
                    oCoreStartScene <= (word_idx == '0);
                    word_idx        <= word_idx + 1'b1;
                end
                if (db_xfer) begin
                    oCoreDesc          <= iDatabaseDesc;
                    oCoreValid         <= 1'b1;
                    oCoreStartDatabase <= (word_idx == '0);
                    word_idx           <= word_idx + 1'b1;
                    if (last_word) begin
                        if (last_db) begin
                            db_idx <= '0;
                            if (!last_scene) begin
                                scene_idx       <= scene_idx + 1'b1;
                                oRewindDatabase <= 1'b1;
                            end
                        end else begin
                            db_idx <= db_idx + 1'b1;
                        end
                    end
                end
                if (counting && iCoreMatchValid) begin
                    if (result_due) begin
                        oResultWrite <= 1'b1;
                        if (iCoreMatch)      oResultIndex <= iCoreMatchIndex;
                        else if (have_match) oResultIndex <= match_index;
                        else                 oResultIndex <= NO_MATCH;
                        write_count <= write_count + 1'b1;
                        valid_count <= '0;
                        have_match  <= 1'b0;
                    end else begin
                        valid_count <= valid_count + 1'b1;
                        if (iCoreMatch) begin
                            have_match  <= 1'b1;
                            match_index <= iCoreMatchIndex;
                        end
                    end
                end
                if ((state == PAD) && pad_needed) begin
                    oResultWrite <= 1'b1;
                    write_count  <= write_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_match_descriptor_sequencer.sv
// Self-checking bench for match_descriptor_sequencer: a job table driven through
// a FIFO/core model, plus a hand-written mid-job reset sequence.
// Expected padding follows MATCH_DESCRIPTOR_SEQUENCER_PAD_EN when it is defined.
module tb_match_descriptor_sequencer;

    localparam int DESC_W    = 16;
    localparam int WPD       = 64;
    localparam int IDX_W     = 12;
    localparam int PAD_BLOCK = 256;
    localparam logic [IDX_W-1:0] NO_MATCH = '1;

    logic              iClk = 1'b0;
    logic              iReset;
    logic              iStart;
    logic [IDX_W-1:0]  iSceneCount;
    logic [IDX_W-1:0]  iDatabaseCount;
    logic [DESC_W-1:0] iSceneDesc;
    logic [DESC_W-1:0] iDatabaseDesc;
    logic              iSceneEmpty;
    logic              iDatabaseEmpty;
    logic              oReadScene;
    logic              oReadDatabase;
    logic              oRewindDatabase;
    logic [DESC_W-1:0] oCoreDesc;
    logic              oCoreValid;
    logic              oCoreStartScene;
    logic              oCoreStartDatabase;
    logic              iCoreMatchValid;
    logic              iCoreMatch;
    logic [IDX_W-1:0]  iCoreMatchIndex;
    logic [IDX_W-1:0]  oResultIndex;
    logic              oResultWrite;
    logic              oBusy;
    logic              oDone;

    match_descriptor_sequencer #(
        .DESC_W(DESC_W), .WORDS_PER_DESC(WPD), .IDX_W(IDX_W), .PAD_BLOCK(PAD_BLOCK)
    ) dut (
        .iClk(iClk), .iReset(iReset), .iStart(iStart),
        .iSceneCount(iSceneCount), .iDatabaseCount(iDatabaseCount),
        .iSceneDesc(iSceneDesc), .iDatabaseDesc(iDatabaseDesc),
        .iSceneEmpty(iSceneEmpty), .iDatabaseEmpty(iDatabaseEmpty),
        .oReadScene(oReadScene), .oReadDatabase(oReadDatabase),
        .oRewindDatabase(oRewindDatabase),
        .oCoreDesc(oCoreDesc), .oCoreValid(oCoreValid),
        .oCoreStartScene(oCoreStartScene), .oCoreStartDatabase(oCoreStartDatabase),
        .iCoreMatchValid(iCoreMatchValid), .iCoreMatch(iCoreMatch),
        .iCoreMatchIndex(iCoreMatchIndex),
        .oResultIndex(oResultIndex), .oResultWrite(oResultWrite),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        string name;
        int    scenes;
        int    dbs;
        int    match_scene;
        int    match_mask;
        bit    toggle_empty;
        bit    poke_start;
        int    exp_results;
        int    exp_rewinds;
        int    exp_core_words;
        int    exp_first;
        int    exp_done_cyc;
    } job_t;

    int vectors     = 0;
    int miscompares = 0;
    int scene_ptr   = 0;
    int db_ptr      = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int paddedTotal(input int n);
`ifdef MATCH_DESCRIPTOR_SEQUENCER_PAD_EN
        return ((n + PAD_BLOCK - 1) / PAD_BLOCK) * PAD_BLOCK;
`else
        return n;
`endif
    endfunction

    function automatic bit isMatch(input job_t j, input int s, input int d);
        return (s == j.match_scene) && (((j.match_mask >> d) & 1) != 0);
    endfunction

    // FIFO heads: scene words carry bit 15 set, database words are their ordinal
    task automatic applyStimulus(input job_t j, input int c);
        iSceneEmpty    = j.toggle_empty && (((c / 3) % 2) == 1);
        iDatabaseEmpty = j.toggle_empty && (((c / 5) % 2) == 1);
        iSceneDesc     = 16'h8000 | DESC_W'(scene_ptr);
        iDatabaseDesc  = DESC_W'(db_ptr);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, oBusy, 0);
        checkOutput({tag, "_done"}, oDone, 0);
        checkOutput({tag, "_read_scene"}, oReadScene, 0);
        checkOutput({tag, "_read_db"}, oReadDatabase, 0);
        checkOutput({tag, "_rewind"}, oRewindDatabase, 0);
        checkOutput({tag, "_core_valid"}, oCoreValid, 0);
        checkOutput({tag, "_start_scene"}, oCoreStartScene, 0);
        checkOutput({tag, "_start_db"}, oCoreStartDatabase, 0);
        checkOutput({tag, "_write"}, oResultWrite, 0);
        checkOutput({tag, "_index"}, oResultIndex, NO_MATCH);
    endtask

    task automatic runJob(input job_t j, input int abort_at);
        int per, k, writes, rewinds, pops, cyc, budget, s, r, d;
        bit prev_pop_s, prev_pop_d, prev_rewind, expect_wr, pulse, aborted;
        logic [31:0] first_seen;
        logic [DESC_W-1:0] exp_desc;
        logic [IDX_W-1:0] best;
        logic [IDX_W-1:0] exp_res[$];
        int exp_total;

        $display("[TB] job %s scenes=%0d dbs=%0d", j.name, j.scenes, j.dbs);
        per = WPD * (1 + j.dbs);
        for (int si = 0; si < j.scenes && j.dbs > 0; si++) begin
            best = NO_MATCH;
            for (int di = 0; di < j.dbs; di++)
                if (isMatch(j, si, di)) best = IDX_W'(di);
            exp_res.push_back(best);
        end
        exp_total = paddedTotal(exp_res.size());
        while (exp_res.size() < exp_total) exp_res.push_back(NO_MATCH);

        scene_ptr = 0;
        db_ptr = 0;
        iSceneCount = IDX_W'(j.scenes);
        iDatabaseCount = IDX_W'(j.dbs);
        iStart = 1'b1;
        iCoreMatchValid = 1'b0;
        applyStimulus(j, 0);
        prev_pop_s = oReadScene && !iSceneEmpty;
        prev_pop_d = oReadDatabase && !iDatabaseEmpty;
        prev_rewind = oRewindDatabase;
        @(negedge iClk);
        iStart = 1'b0;

        k = 0; writes = 0; rewinds = 0; pops = 0; cyc = 0;
        s = 0; r = 0; d = 0;
        budget = 2 * j.exp_core_words + 1000;
        first_seen = '1;
        expect_wr = 1'b0;
        aborted = 1'b0;

        while (!oDone && cyc < budget) begin
            if (prev_pop_s) scene_ptr++;
            if (prev_rewind) db_ptr = 0;
            else if (prev_pop_d) db_ptr++;

            checkOutput("core_valid", oCoreValid, prev_pop_s | prev_pop_d);
            pulse = 1'b0;
            if (oCoreValid) begin
                s = k / per;
                r = k % per;
                if (r < WPD) begin
                    exp_desc = 16'h8000 | DESC_W'(s * WPD + r);
                    checkOutput("start_scene", oCoreStartScene, r == 0);
                    checkOutput("start_db", oCoreStartDatabase, 0);
                end else begin
                    d = (r - WPD) / WPD;
                    exp_desc = DESC_W'(r - WPD);
                    checkOutput("start_scene", oCoreStartScene, 0);
                    checkOutput("start_db", oCoreStartDatabase, ((r - WPD) % WPD) == 0);
                    pulse = (((r - WPD) % WPD) == WPD - 1);
                end
                checkOutput("core_desc", oCoreDesc, exp_desc);
                k++;
            end

            if (expect_wr) checkOutput("write_latency", oResultWrite, 1);
            if (oResultWrite) begin
                if (writes < exp_res.size()) checkOutput("result_index", oResultIndex, exp_res[writes]);
                else checkOutput("excess_write", writes + 1, exp_res.size());
                if (writes == 0) first_seen = 32'(oResultIndex);
                writes++;
            end else begin
                checkOutput("idle_index", oResultIndex, NO_MATCH);
            end
            if (oRewindDatabase) rewinds++;

            expect_wr = 1'b0;
            iCoreMatchValid = 1'b0;
            iCoreMatch = 1'b0;
            iCoreMatchIndex = 12'h5A5;
            if (pulse) begin
                iCoreMatchValid = 1'b1;
                iCoreMatch = isMatch(j, s, d);
                iCoreMatchIndex = IDX_W'(d);
                expect_wr = (d == j.dbs - 1);
            end
            if (j.poke_start && cyc == 30) begin
                iStart = 1'b1;
                iSceneCount = 12'd7;
                iDatabaseCount = 12'd7;
            end else begin
                iStart = 1'b0;
                iSceneCount = IDX_W'(j.scenes);
                iDatabaseCount = IDX_W'(j.dbs);
            end
            applyStimulus(j, cyc + 1);
            prev_pop_s = oReadScene && !iSceneEmpty;
            prev_pop_d = oReadDatabase && !iDatabaseEmpty;
            if (prev_pop_s || prev_pop_d) pops++;
            prev_rewind = oRewindDatabase;

            if (abort_at > 0 && k >= abort_at) begin
                checkOutput("abort_in_load_db", oReadDatabase, 1);
                iReset = 1'b1;
                iStart = 1'b1;
                iCoreMatchValid = 1'b0;
                @(negedge iClk);
                checkResetOutputs("abort");
                iReset = 1'b0;
                iStart = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(negedge iClk);
            cyc++;
        end

        if (!aborted) begin
            checkOutput("done_reached", oDone, 1);
            checkOutput("busy_at_done", oBusy, 0);
            checkOutput("core_words", k, j.exp_core_words);
            checkOutput("fifo_pops", pops, j.exp_core_words);
            checkOutput("total_writes", writes, paddedTotal(j.exp_results));
            checkOutput("rewinds", rewinds, j.exp_rewinds);
            checkOutput("first_result", first_seen, j.exp_first);
            if (j.exp_done_cyc >= 0) checkOutput("done_latency", cyc, j.exp_done_cyc);
            repeat (2) begin
                @(negedge iClk);
                checkOutput("done_hold", oDone, 1);
                checkOutput("no_write_in_done", oResultWrite, 0);
            end
        end
    endtask

    job_t jobs[7];
    job_t reset_job;

    initial begin
        jobs[0] = '{name:"basic",        scenes:2,   dbs:3, match_scene:0,  match_mask:'b010,
                    toggle_empty:0, poke_start:1, exp_results:2,   exp_rewinds:1,
                    exp_core_words:512,   exp_first:1,       exp_done_cyc:-1};
        jobs[1] = '{name:"empty_toggle", scenes:2,   dbs:3, match_scene:0,  match_mask:'b010,
                    toggle_empty:1, poke_start:0, exp_results:2,   exp_rewinds:1,
                    exp_core_words:512,   exp_first:1,       exp_done_cyc:-1};
        jobs[2] = '{name:"scene_zero",   scenes:0,   dbs:3, match_scene:-1, match_mask:0,
                    toggle_empty:0, poke_start:0, exp_results:0,   exp_rewinds:0,
                    exp_core_words:0,     exp_first:-1,      exp_done_cyc:1};
        jobs[3] = '{name:"db_zero",      scenes:2,   dbs:0, match_scene:-1, match_mask:0,
                    toggle_empty:0, poke_start:0, exp_results:0,   exp_rewinds:0,
                    exp_core_words:0,     exp_first:-1,      exp_done_cyc:1};
        jobs[4] = '{name:"latest_match", scenes:1,   dbs:4, match_scene:0,  match_mask:'b0101,
                    toggle_empty:0, poke_start:0, exp_results:1,   exp_rewinds:0,
                    exp_core_words:320,   exp_first:2,       exp_done_cyc:-1};
        jobs[5] = '{name:"three_by_two", scenes:3,   dbs:2, match_scene:-1, match_mask:0,
                    toggle_empty:0, poke_start:0, exp_results:3,   exp_rewinds:2,
                    exp_core_words:576,   exp_first:'hFFF,   exp_done_cyc:-1};
        jobs[6] = '{name:"many_scenes",  scenes:256, dbs:1, match_scene:-1, match_mask:0,
                    toggle_empty:0, poke_start:0, exp_results:256, exp_rewinds:255,
                    exp_core_words:32768, exp_first:'hFFF,   exp_done_cyc:-1};

        iReset = 1'b1;
        iStart = 1'b0;
        iSceneCount = '0;
        iDatabaseCount = '0;
        iSceneDesc = '0;
        iDatabaseDesc = '0;
        iSceneEmpty = 1'b0;
        iDatabaseEmpty = 1'b0;
        iCoreMatchValid = 1'b0;
        iCoreMatch = 1'b0;
        iCoreMatchIndex = '0;
        repeat (3) @(negedge iClk);
        checkResetOutputs("reset");
        iReset = 1'b0;
        @(negedge iClk);
        checkResetOutputs("idle");

        for (int i = 0; i < 6; i++) runJob(jobs[i], 0);

        // Reset while loading the database for scene 1, then rerun the same job
        reset_job = jobs[0];
        reset_job.name = "abort_then_rerun";
        reset_job.poke_start = 0;
        runJob(reset_job, WPD * 4 + WPD + 5);
        repeat (3) begin
            @(negedge iClk);
            checkOutput("post_abort_busy", oBusy, 0);
            checkOutput("post_abort_write", oResultWrite, 0);
        end
        runJob(reset_job, 0);

        runJob(jobs[6], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
